// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single ready/valid memory port.
// Supports one outstanding read and either data-priority with a starvation guard or round-robin.
module mem_arbiter #(
  parameter int XLEN          = 32,
  parameter int DATA_PRIORITY = 1,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              iram_req,
  input  logic [XLEN-1:0]   iram_addr,
  output logic              iram_ready,
  output logic              iram_rvalid,
  output logic [XLEN-1:0]   iram_rdata,
  input  logic              dram_req,
  input  logic              dram_write,
  input  logic [XLEN/8-1:0] dram_wstrb,
  input  logic [XLEN-1:0]   dram_addr,
  input  logic [XLEN-1:0]   dram_wdata,
  output logic              dram_ready,
  output logic              dram_rvalid,
  output logic [XLEN-1:0]   dram_rdata,
  output logic              mem_req,
  output logic              mem_write,
  output logic [XLEN/8-1:0] mem_wstrb,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_owner_d;
  logic       r_rsp_d;
  logic       r_last_d;
  logic [3:0] r_starve;

  logic w_gnt_vld;
  logic w_gnt_d;
  logic w_live;
  logic w_acc;
  logic w_rsp;
  logic w_is_wr;

  // Grant selection: HOLD replays the locked owner, IDLE and the response cycle of WAIT arbitrate.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_d   = 1'b0;
    if (r_state == S_HOLD) begin
      w_gnt_d   = r_owner_d;
      w_gnt_vld = r_owner_d ? dram_req : iram_req;
    end else if ((r_state == S_IDLE) || ((r_state == S_WAIT) && mem_rvalid)) begin
      if (iram_req && dram_req) begin
        w_gnt_vld = 1'b1;
        if (DATA_PRIORITY != 0) w_gnt_d = (r_starve != LP_LIMIT);
        else                    w_gnt_d = ~r_last_d;
      end else begin
        w_gnt_vld = iram_req | dram_req;
        w_gnt_d   = dram_req;
      end
    end
  end

  // Combinational grant must not leak onto the bus while reset is held.
  assign w_live  = w_gnt_vld & rst_b;
  assign w_acc   = w_live & mem_ready;
  assign w_rsp   = (r_state == S_WAIT) & mem_rvalid;
  assign w_is_wr = w_gnt_d & dram_write;

  always_comb begin
    w_state_nxt = r_state;
    if (w_acc)                  w_state_nxt = w_is_wr ? S_IDLE : S_WAIT;
    else if (w_gnt_vld)         w_state_nxt = S_HOLD;
    else if (r_state == S_HOLD) w_state_nxt = S_IDLE;
    else if (w_rsp)             w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_owner_d <= 1'b0;
      r_rsp_d   <= 1'b0;
      r_last_d  <= 1'b1;
      r_starve  <= 4'd0;
    end else begin
      if (w_gnt_vld && !w_acc) r_owner_d <= w_gnt_d;
      if (w_acc && !w_is_wr)   r_rsp_d   <= w_gnt_d;
      if (w_acc)               r_last_d  <= w_gnt_d;
      // Saturate at the limit so the equality test keeps forcing the instruction port.
      if (w_acc && w_gnt_d && iram_req && (r_starve != LP_LIMIT)) r_starve <= r_starve + 4'd1;
      else if (w_acc && !w_gnt_d)                               r_starve <= 4'd0;
    end
  end

  assign mem_req   = w_live;
  assign mem_write = w_live & w_is_wr;
  assign mem_wstrb = w_gnt_d ? dram_wstrb : '0;
  assign mem_addr  = w_gnt_d ? dram_addr  : iram_addr;
  assign mem_wdata = w_gnt_d ? dram_wdata : '0;

  assign iram_ready  = w_live & ~w_gnt_d & mem_ready;
  assign dram_ready  = w_live &  w_gnt_d & mem_ready;
  assign iram_rvalid = w_rsp & ~r_rsp_d;
  assign dram_rvalid = w_rsp &  r_rsp_d;
  assign iram_rdata  = mem_rdata;
  assign dram_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 is round-robin, instance 1 is data-priority.
// Directed scenarios plus randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;

  logic clk;
  logic rst_b;

  logic        ireq[2], dreq[2], dwr[2], mrdy[2], mrv[2];
  logic [31:0] iaddr[2], daddr[2], dwdata[2], mrdata[2];
  logic [3:0]  dwstrb[2];
  logic        irdy[2], irv[2], drdy[2], drv[2], mreq[2], mwr[2];
  logic [31:0] irdata[2], drdata[2], maddr[2], mwdata[2];
  logic [3:0]  mwstrb[2];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(.XLEN(32), .DATA_PRIORITY(g), .STARVE_LIMIT(4)) u_dut (
      .clk(clk), .rst_b(rst_b),
      .iram_req(ireq[g]), .iram_addr(iaddr[g]), .iram_ready(irdy[g]),
      .iram_rvalid(irv[g]), .iram_rdata(irdata[g]),
      .dram_req(dreq[g]), .dram_write(dwr[g]), .dram_wstrb(dwstrb[g]),
      .dram_addr(daddr[g]), .dram_wdata(dwdata[g]), .dram_ready(drdy[g]),
      .dram_rvalid(drv[g]), .dram_rdata(drdata[g]),
      .mem_req(mreq[g]), .mem_write(mwr[g]), .mem_wstrb(mwstrb[g]),
      .mem_addr(maddr[g]), .mem_wdata(mwdata[g]), .mem_ready(mrdy[g]),
      .mem_rvalid(mrv[g]), .mem_rdata(mrdata[g])
    );
  end

  // Reference model: port ids 0 = instruction, 1 = data, -1 = none.
  int m_lock[2], m_rsp[2], m_starve[2], m_last[2];
  bit m_out[2];
  int e_port[2];
  bit e_irdy[2], e_drdy[2], e_irv[2], e_drv[2];

  function automatic void model_reset(int k);
    m_lock[k] = -1; m_rsp[k] = 0; m_starve[k] = 0; m_last[k] = 1; m_out[k] = 0;
  endfunction

  function automatic void model_eval(int k);
    bit can_arb;
    can_arb = !m_out[k] || mrv[k];
    e_port[k] = -1;
    if (m_lock[k] >= 0) begin
      if ((m_lock[k] == 0) ? ireq[k] : dreq[k]) e_port[k] = m_lock[k];
    end else if (can_arb) begin
      if (ireq[k] && dreq[k]) begin
        if (k == 1) e_port[k] = (m_starve[k] == 4) ? 0 : 1;
        else        e_port[k] = 1 - m_last[k];
      end else if (ireq[k]) e_port[k] = 0;
      else if (dreq[k])     e_port[k] = 1;
    end
    e_irdy[k] = (e_port[k] == 0) && mrdy[k];
    e_drdy[k] = (e_port[k] == 1) && mrdy[k];
    e_irv[k]  = m_out[k] && mrv[k] && (m_rsp[k] == 0);
    e_drv[k]  = m_out[k] && mrv[k] && (m_rsp[k] == 1);
  endfunction

  function automatic void model_commit(int k);
    bit acc;
    acc = (e_port[k] >= 0) && mrdy[k];
    if (m_out[k] && mrv[k]) m_out[k] = 0;
    if (acc) begin
      if (!(e_port[k] == 1 && dwr[k])) begin
        m_out[k] = 1;
        m_rsp[k] = e_port[k];
      end
      m_lock[k] = -1;
      m_last[k] = e_port[k];
      if (e_port[k] == 1 && ireq[k]) m_starve[k] = (m_starve[k] < 4) ? m_starve[k] + 1 : 4;
      if (e_port[k] == 0) m_starve[k] = 0;
    end else begin
      m_lock[k] = e_port[k];
    end
  endfunction

  task automatic clr_inputs();
    for (int k = 0; k < 2; k++) begin
      ireq[k] = 0; dreq[k] = 0; dwr[k] = 0; mrdy[k] = 0; mrv[k] = 0;
      iaddr[k] = 0; daddr[k] = 0; dwdata[k] = 0; mrdata[k] = 0; dwstrb[k] = 0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_b = 0;
    clr_inputs();
    @(negedge clk);
    rst_b = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      ireq[k] = 1; dreq[k] = 1; mrdy[k] = 1; mrv[k] = 1;
    end
    #3;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (mreq[k] !== 1'b0 || irdy[k] !== 1'b0 || drdy[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_bus k=%0d got req/irdy/drdy %b%b%b exp 000", k, mreq[k], irdy[k], drdy[k]);
      end
      checks++;
      if (irv[k] !== 1'b0 || drv[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_rvalid k=%0d got %b%b exp 00", k, irv[k], drv[k]);
      end
    end
    @(negedge clk);
    clr_inputs();
    rst_b = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_data_priority();
    logic exp_d, prev_d;
    apply_reset();
    ireq[1] = 1; iaddr[1] = 32'h100; dreq[1] = 1; daddr[1] = 32'h200;
    mrdy[1] = 1; mrv[1] = 1; mrdata[1] = 32'h5555AAAA;
    prev_d = 0;
    for (int c = 0; c < 10; c++) begin
      exp_d = (c != 4) && (c != 9);
      @(negedge clk);
      checks++;
      if (maddr[1] !== (exp_d ? 32'h200 : 32'h100)) begin
        errors++;
        $display("FAIL prio_addr c=%0d got %h exp %h", c, maddr[1], exp_d ? 32'h200 : 32'h100);
      end
      checks++;
      if (drdy[1] !== exp_d || irdy[1] !== !exp_d) begin
        errors++;
        $display("FAIL prio_ready c=%0d got i%b d%b exp d=%b", c, irdy[1], drdy[1], exp_d);
      end
      if (c > 0) begin
        checks++;
        if (drv[1] !== prev_d || irv[1] !== !prev_d) begin
          errors++;
          $display("FAIL prio_rvalid c=%0d got i%b d%b exp d=%b", c, irv[1], drv[1], prev_d);
        end
      end
      prev_d = exp_d;
      @(posedge clk); #1;
    end
    clr_inputs();
  endtask

  task automatic test_hold();
    apply_reset();
    dreq[1] = 1; dwr[1] = 1; daddr[1] = 32'h40; dwstrb[1] = 4'b0011; dwdata[1] = 32'h12345678;
    iaddr[1] = 32'h80;
    for (int c = 1; c <= 5; c++) begin
      if (c >= 2) ireq[1] = 1;
      mrdy[1] = (c >= 4);
      if (c == 5) dreq[1] = 0;
      @(negedge clk);
      if (c <= 4) begin
        checks++;
        if (mreq[1] !== 1'b1 || maddr[1] !== 32'h40 || mwr[1] !== 1'b1 ||
            mwstrb[1] !== 4'b0011 || mwdata[1] !== 32'h12345678) begin
          errors++;
          $display("FAIL hold_payload c=%0d got req%b a%h w%b s%b d%h exp 1/40/1/0011/12345678",
                   c, mreq[1], maddr[1], mwr[1], mwstrb[1], mwdata[1]);
        end
        checks++;
        if (irdy[1] !== 1'b0 || drdy[1] !== (c == 4)) begin
          errors++;
          $display("FAIL hold_ready c=%0d got i%b d%b exp i0 d%b", c, irdy[1], drdy[1], c == 4);
        end
      end else begin
        checks++;
        if (mreq[1] !== 1'b1 || maddr[1] !== 32'h80 || mwr[1] !== 1'b0 ||
            mwstrb[1] !== 4'b0 || mwdata[1] !== 32'h0 || irdy[1] !== 1'b1) begin
          errors++;
          $display("FAIL hold_next_iram got req%b a%h w%b s%b d%h irdy%b exp 1/80/0/0000/0/1",
                   mreq[1], maddr[1], mwr[1], mwstrb[1], mwdata[1], irdy[1]);
        end
      end
      @(posedge clk); #1;
    end
    clr_inputs();
  endtask

  task automatic test_read_resp();
    apply_reset();
    ireq[1] = 1; iaddr[1] = 32'h80; mrdy[1] = 1;
    @(negedge clk);
    checks++;
    if (irdy[1] !== 1'b1 || maddr[1] !== 32'h80) begin
      errors++;
      $display("FAIL rd_accept got irdy%b a%h exp 1/80", irdy[1], maddr[1]);
    end
    @(posedge clk); #1;
    ireq[1] = 0; dreq[1] = 1; daddr[1] = 32'h300;
    @(negedge clk);
    checks++;
    if (mreq[1] !== 1'b0 || drdy[1] !== 1'b0 || irv[1] !== 1'b0) begin
      errors++;
      $display("FAIL rd_wait got req%b drdy%b irv%b exp 000", mreq[1], drdy[1], irv[1]);
    end
    @(posedge clk); #1;
    mrv[1] = 1; mrdata[1] = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (irv[1] !== 1'b1 || drv[1] !== 1'b0) begin
      errors++;
      $display("FAIL rd_rvalid got i%b d%b exp i1 d0", irv[1], drv[1]);
    end
    checks++;
    if (irdata[1] !== 32'hDEADBEEF || drdata[1] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_rdata got %h %h exp deadbeef", irdata[1], drdata[1]);
    end
    checks++;
    if (mreq[1] !== 1'b1 || maddr[1] !== 32'h300 || drdy[1] !== 1'b1) begin
      errors++;
      $display("FAIL rd_b2b got req%b a%h drdy%b exp 1/300/1", mreq[1], maddr[1], drdy[1]);
    end
    @(posedge clk); #1;
    dreq[1] = 0; mrv[1] = 0;
    @(negedge clk);
    checks++;
    if (irv[1] !== 1'b0 || drv[1] !== 1'b0) begin
      errors++;
      $display("FAIL rd_one_cycle got i%b d%b exp 00", irv[1], drv[1]);
    end
    @(posedge clk); #1;
    mrv[1] = 1; mrdata[1] = 32'h0BADF00D;
    @(negedge clk);
    checks++;
    if (drv[1] !== 1'b1 || irv[1] !== 1'b0) begin
      errors++;
      $display("FAIL rd_data_rvalid got i%b d%b exp i0 d1", irv[1], drv[1]);
    end
    @(posedge clk); #1;
    clr_inputs();
  endtask

  task automatic test_flush();
    apply_reset();
    dreq[1] = 1; daddr[1] = 32'h44;
    @(negedge clk);
    checks++;
    if (mreq[1] !== 1'b1 || drdy[1] !== 1'b0) begin
      errors++;
      $display("FAIL flush_hold got req%b drdy%b exp 1/0", mreq[1], drdy[1]);
    end
    @(posedge clk); #1;
    dreq[1] = 0; mrv[1] = 1;
    @(negedge clk);
    checks++;
    if (mreq[1] !== 1'b0 || irv[1] !== 1'b0 || drv[1] !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle got req%b irv%b drv%b exp 000", mreq[1], irv[1], drv[1]);
    end
    @(posedge clk); #1;
    ireq[1] = 1; iaddr[1] = 32'h88; mrdy[1] = 1;
    @(negedge clk);
    checks++;
    if (irdy[1] !== 1'b1 || maddr[1] !== 32'h88 || irv[1] !== 1'b0 || drv[1] !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle got irdy%b a%h irv%b drv%b exp 1/88/0/0", irdy[1], maddr[1], irv[1], drv[1]);
    end
    @(posedge clk); #1;
    clr_inputs();
    mrv[1] = 1;
    @(posedge clk); #1;
    clr_inputs();
  endtask

  task automatic test_round_robin();
    logic exp_d;
    apply_reset();
    ireq[0] = 1; iaddr[0] = 32'h100; dreq[0] = 1; daddr[0] = 32'h200;
    mrdy[0] = 1; mrv[0] = 1;
    for (int c = 0; c < 8; c++) begin
      exp_d = c[0];
      @(negedge clk);
      checks++;
      if (irdy[0] !== !exp_d || drdy[0] !== exp_d || maddr[0] !== (exp_d ? 32'h200 : 32'h100)) begin
        errors++;
        $display("FAIL rr_grant c=%0d got i%b d%b a%h exp d=%b", c, irdy[0], drdy[0], maddr[0], exp_d);
      end
      @(posedge clk); #1;
    end
    clr_inputs();
  endtask

  task automatic test_reset_wait();
    apply_reset();
    ireq[1] = 1; iaddr[1] = 32'h80; mrdy[1] = 1;
    @(posedge clk); #1;
    ireq[1] = 0;
    @(negedge clk);
    rst_b = 0;
    dreq[1] = 1; mrv[1] = 1;
    #1;
    checks++;
    if (mreq[1] !== 1'b0 || drdy[1] !== 1'b0 || irv[1] !== 1'b0 || drv[1] !== 1'b0) begin
      errors++;
      $display("FAIL rstw_during got req%b drdy%b irv%b drv%b exp 0000", mreq[1], drdy[1], irv[1], drv[1]);
    end
    dreq[1] = 0; mrv[1] = 0;
    @(negedge clk);
    rst_b = 1;
    @(posedge clk); #1;
    mrv[1] = 1;
    @(negedge clk);
    checks++;
    if (irv[1] !== 1'b0 || drv[1] !== 1'b0) begin
      errors++;
      $display("FAIL rstw_stale_rvalid got i%b d%b exp 00", irv[1], drv[1]);
    end
    @(posedge clk); #1;
    mrv[1] = 0; dreq[1] = 1; daddr[1] = 32'h90;
    @(negedge clk);
    checks++;
    if (mreq[1] !== 1'b1 || drdy[1] !== 1'b1 || maddr[1] !== 32'h90) begin
      errors++;
      $display("FAIL rstw_idle got req%b drdy%b a%h exp 1/1/90", mreq[1], drdy[1], maddr[1]);
    end
    @(posedge clk); #1;
    clr_inputs();
  endtask

  task automatic test_random();
    bit last_irdy[2], last_drdy[2];
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      model_reset(k);
      last_irdy[k] = 0; last_drdy[k] = 0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        if (!ireq[k] || last_irdy[k]) begin
          ireq[k] = 1'($urandom_range(0, 1)); iaddr[k] = $urandom;
        end else if ($urandom_range(0, 15) == 0) ireq[k] = 0;
        if (!dreq[k] || last_drdy[k]) begin
          dreq[k] = 1'($urandom_range(0, 1)); daddr[k] = $urandom; dwdata[k] = $urandom;
          dwr[k] = 1'($urandom_range(0, 1)); dwstrb[k] = 4'($urandom_range(0, 15));
        end else if ($urandom_range(0, 15) == 0) dreq[k] = 0;
        mrdy[k] = ($urandom_range(0, 2) != 0);
        mrv[k] = ($urandom_range(0, 2) == 0);
        mrdata[k] = $urandom;
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        model_eval(k);
        checks++;
        if (mreq[k] !== (e_port[k] >= 0) || irdy[k] !== e_irdy[k] || drdy[k] !== e_drdy[k]) begin
          errors++;
          $display("FAIL rnd_grant cyc=%0d k=%0d got req%b i%b d%b exp port=%0d i%b d%b",
                   cyc, k, mreq[k], irdy[k], drdy[k], e_port[k], e_irdy[k], e_drdy[k]);
        end
        checks++;
        if (irv[k] !== e_irv[k] || drv[k] !== e_drv[k]) begin
          errors++;
          $display("FAIL rnd_rvalid cyc=%0d k=%0d got i%b d%b exp i%b d%b",
                   cyc, k, irv[k], drv[k], e_irv[k], e_drv[k]);
        end
        checks++;
        if (irdata[k] !== mrdata[k] || drdata[k] !== mrdata[k]) begin
          errors++;
          $display("FAIL rnd_rdata cyc=%0d k=%0d got %h %h exp %h", cyc, k, irdata[k], drdata[k], mrdata[k]);
        end
        if (e_port[k] == 1) begin
          checks++;
          if (maddr[k] !== daddr[k] || mwr[k] !== dwr[k] || mwstrb[k] !== dwstrb[k] || mwdata[k] !== dwdata[k]) begin
            errors++;
            $display("FAIL rnd_dpayload cyc=%0d k=%0d got a%h w%b s%h d%h exp a%h w%b s%h d%h",
                     cyc, k, maddr[k], mwr[k], mwstrb[k], mwdata[k], daddr[k], dwr[k], dwstrb[k], dwdata[k]);
          end
        end else if (e_port[k] == 0) begin
          checks++;
          if (maddr[k] !== iaddr[k] || mwr[k] !== 1'b0 || mwstrb[k] !== 4'h0 || mwdata[k] !== 32'h0) begin
            errors++;
            $display("FAIL rnd_ipayload cyc=%0d k=%0d got a%h w%b s%h d%h exp a%h w0 s0 d0",
                     cyc, k, maddr[k], mwr[k], mwstrb[k], mwdata[k], iaddr[k]);
          end
        end
        last_irdy[k] = e_irdy[k];
        last_drdy[k] = e_drdy[k];
        model_commit(k);
      end
      @(posedge clk); #1;
    end
    clr_inputs();
  endtask

  initial begin
    rst_b = 0;
    clr_inputs();
    test_reset();
    test_data_priority();
    test_hold();
    test_read_resp();
    test_flush();
    test_round_robin();
    test_reset_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: XLEN, default 32, data/address width.
REQ-002 Parameter: DATA_PRIORITY, default 1; 1 = data port wins conflicts (with starvation guard), 0 = round-robin.
REQ-003 Parameter: STARVE_LIMIT, default 4, range 1..15; consecutive conflicting data grants before the instruction port is forced.
REQ-004 One clock; reset is asynchronous and active-low: clk input 1, rst_b input 1 (async, active-low).
REQ-005 Instruction port: iram_req input 1; iram_addr input XLEN; iram_ready output 1; iram_rvalid output 1; iram_rdata output XLEN.
REQ-006 Data port: dram_req input 1; dram_write input 1; dram_wstrb input XLEN/8; dram_addr input XLEN; dram_wdata input XLEN; dram_ready output 1; dram_rvalid output 1; dram_rdata output XLEN.
REQ-007 Shared memory port: mem_req output 1; mem_write output 1; mem_wstrb output XLEN/8; mem_addr output XLEN; mem_wdata output XLEN; mem_ready input 1; mem_rvalid input 1; mem_rdata input XLEN.

Function
REQ-008 A transfer is accepted in a cycle with mem_req & mem_ready; the granted port's ready equals mem_ready in that cycle, the other port's ready is 0.
REQ-009 Requesters hold req and payload stable until ready; no stall added (zero-cycle pass-through when memory is ready).
REQ-010 States: IDLE (no grant locked), HOLD (grant locked, not yet accepted), WAIT (one read outstanding).
REQ-011 IDLE: arbitrate combinationally; present the winner on mem_*; accepted read -> WAIT; accepted write -> IDLE; not accepted -> HOLD with owner latched.
REQ-012 HOLD: present only the locked owner regardless of the other port; accepted read -> WAIT; accepted write -> IDLE.
REQ-013 HOLD with owner req deasserted (flush): mem_req = 0 that cycle, next state IDLE, no transfer, counters unchanged.
REQ-014 WAIT: mem_req = 0 except in the cycle mem_rvalid = 1; that cycle the response is routed and arbitration proceeds as in IDLE (back-to-back).
REQ-015 At most one outstanding read; response owner held in a register; rvalid asserted only on that port for exactly one cycle.
REQ-016 iram_rdata and dram_rdata both equal mem_rdata (unqualified).
REQ-017 mem_rvalid in IDLE/HOLD is ignored; neither rvalid asserts.
REQ-018 Instruction-port transfers drive mem_write = 0, mem_wstrb = 0, mem_wdata = 0.
REQ-019 DATA_PRIORITY=1: conflict (both req in an arbitration cycle) -> data wins unless starve_cnt == STARVE_LIMIT, then instruction wins.
REQ-020 starve_cnt increments (saturating) on each accepted data transfer while iram_req = 1; clears on an accepted instruction transfer.
REQ-021 DATA_PRIORITY=0: conflict -> grant the port not granted in the last accepted transfer; last-grant register updates only on acceptance.
REQ-022 Single requester always wins regardless of counters.

Reset
REQ-023 rst_b low asynchronously forces: state IDLE, starve_cnt 0, last-grant = data, response owner cleared; mem_req, iram_ready, dram_ready, iram_rvalid, dram_rvalid all 0 while reset asserted.
REQ-024 Reset mid-WAIT discards the outstanding read; a subsequent mem_rvalid is ignored per REQ-017.

Verification
REQ-025 Both req, read addrs 0x100/0x200, mem_ready = 1, DATA_PRIORITY=1, STARVE_LIMIT=4 -> mem_addr 0x200 first; 4 data grants then 0x100 granted on 5th conflict; starve_cnt returns to 0.
REQ-026 dram write addr 0x40, wstrb 4'b0011, mem_ready low 3 cycles then iram_req asserts -> mem_* stays data/0x40 through HOLD, accepted cycle 4, iram presented next cycle.
REQ-027 iram read 0x80, mem_rvalid 2 cycles after acceptance with rdata 0xDEADBEEF -> iram_rvalid = 1 one cycle, dram_rvalid = 0, both rdata = 0xDEADBEEF.
REQ-028 In HOLD drop dram_req (flush) -> mem_req = 0 that cycle, IDLE next, no rvalid ever.
REQ-029 DATA_PRIORITY=0, both req continuous, mem_ready = 1, immediate rvalid -> grants alternate I,D,I,D starting with instruction.
REQ-030 Assert rst_b low in WAIT, release, then pulse mem_rvalid -> no rvalid on either port, state IDLE.
